// File: rtl/sc_frame_shifter.sv
// sc_frame_shifter: parameterised slow-control serializer with chip reset,
// start/busy/done handshake and optional readback-compare pass.
`default_nettype none

module sc_frame_shifter #(
  parameter int FRAME_W     = 829,
  parameter int CLK_DIV     = 4,
  parameter int RSTN_CYCLES = 8,
  parameter int LSB_FIRST   = 1,
  parameter int VERIFY      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               d_sc,
  output logic               ck_sc,
  output logic               rstn_sc,
  input  logic               q_sc
);

  localparam int BW = $clog2(FRAME_W);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = (RSTN_CYCLES > 1) ? $clog2(RSTN_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RSTN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHIPRST = 3'd1,
    S_SHIFT   = 3'd2,
    S_VERIFY  = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [BW-1:0]      bit_cnt, bit_cnt_nx;
  logic [PW-1:0]      phase_cnt, phase_cnt_nx;
  logic               high_ph, high_ph_nx;
  logic [RW-1:0]      rst_cnt, rst_cnt_nx;
  logic [FRAME_W-1:0] shadow, shadow_nx;
  logic               mismatch, mismatch_nx;
  logic               accept;
  logic               shifting_nx;
  logic               cur_bit;
  logic               busy_nx, done_nx, error_nx, d_nx, ck_nx, rstn_nx;

  function automatic logic [BW-1:0] bit_index(input logic [BW-1:0] cnt);
    if (LSB_FIRST != 0) return cnt;
    else                return BIT_LAST - cnt;
  endfunction

  assign cur_bit = shadow[bit_index(bit_cnt)];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      high_ph   <= 1'b0;
      rst_cnt   <= '0;
      shadow    <= '0;
      mismatch  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      d_sc      <= 1'b0;
      ck_sc     <= 1'b0;
      rstn_sc   <= 1'b1;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      phase_cnt <= phase_cnt_nx;
      high_ph   <= high_ph_nx;
      rst_cnt   <= rst_cnt_nx;
      shadow    <= shadow_nx;
      mismatch  <= mismatch_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      error     <= error_nx;
      d_sc      <= d_nx;
      ck_sc     <= ck_nx;
      rstn_sc   <= rstn_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    phase_cnt_nx = phase_cnt;
    high_ph_nx   = high_ph;
    rst_cnt_nx   = rst_cnt;
    shadow_nx    = shadow;
    mismatch_nx  = mismatch;
    accept       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          accept      = 1'b1;
          state_nx    = S_CHIPRST;
          rst_cnt_nx  = '0;
          shadow_nx   = frame;
          mismatch_nx = 1'b0;
        end
      end
      S_CHIPRST: begin
        if (rst_cnt == RST_LAST) begin
          state_nx     = S_SHIFT;
          bit_cnt_nx   = '0;
          phase_cnt_nx = '0;
          high_ph_nx   = 1'b0;
        end else begin
          rst_cnt_nx = rst_cnt + 1'b1;
        end
      end
      S_SHIFT, S_VERIFY: begin
        // The chip's tail bit is read just before ck_sc rises.
        if (state == S_VERIFY && !high_ph && phase_cnt == PH_LAST && q_sc != cur_bit)
          mismatch_nx = 1'b1;
        if (phase_cnt == PH_LAST) begin
          phase_cnt_nx = '0;
          if (!high_ph) begin
            high_ph_nx = 1'b1;
          end else begin
            high_ph_nx = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt_nx = '0;
              state_nx   = (state == S_SHIFT && VERIFY != 0) ? S_VERIFY : S_FINISH;
            end else begin
              bit_cnt_nx = bit_cnt + 1'b1;
            end
          end
        end else begin
          phase_cnt_nx = phase_cnt + 1'b1;
        end
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

    // Outputs are registered images of the next state, so they are glitch-free.
    shifting_nx = (state_nx == S_SHIFT) || (state_nx == S_VERIFY);
    busy_nx     = (state_nx == S_CHIPRST) || shifting_nx;
    done_nx     = (state_nx == S_FINISH);
    rstn_nx     = (state_nx != S_CHIPRST);
    ck_nx       = shifting_nx & high_ph_nx;
    d_nx        = shifting_nx & shadow_nx[bit_index(bit_cnt_nx)];
    if (accept)
      error_nx = 1'b0;
    else if (state_nx == S_FINISH)
      error_nx = mismatch_nx;
    else
      error_nx = error;
  end

endmodule

`default_nettype wire

// File: doc/sc_frame_shifter.md
Name: sc_frame_shifter

Overview:
- Generic slow-control serializer, successor to the fixed 829-bit MAROC transmitter.
- Width, bit order, serial clock rate and chip-reset pulse length are parameters.
- Adds a start/busy/done handshake and an optional verify pass. The verify pass shifts the frame a second time and compares the chip's serial output (q_sc) against the frame.
- Sits between the slow-control register bank and the ASIC slow-control pins.

Parameters:
- FRAME_W, 829: frame length in bits (≥2).
- CLK_DIV, 4: clk cycles per ck_sc half-period (≥1). Bit period is 2*CLK_DIV clk cycles.
- RSTN_CYCLES, 8: clk cycles rstn_sc is held low before shifting (≥1).
- LSB_FIRST, 1: 1 = frame[0] shifted first; 0 = frame[FRAME_W-1] shifted first.
- VERIFY, 1: 1 = perform the readback/compare pass; 0 = single pass, error stays 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only when busy=0
- frame  in  FRAME_W  configuration frame; latched into a shadow register on an accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of operation
- error  out  1  readback mismatch flag; held until the next accepted start
- d_sc  out  1  serial data to ASIC
- ck_sc  out  1  serial clock to ASIC (idle low)
- rstn_sc  out  1  active-low ASIC slow-control reset
- q_sc  in  1  ASIC serial output (shift-register tail)

Behaviour:
- Reset values: busy=0, done=0, error=0, d_sc=0, ck_sc=0, rstn_sc=1, state IDLE. Counters and shadow register are cleared.
- rst asserted mid-operation aborts immediately. Outputs take reset values on the next edge; there is no partial completion and no done pulse.

FSM states: IDLE → CHIPRST → SHIFT → [VERIFY] → FINISH → IDLE.
- IDLE:
  - start=1 latches frame and clears error; the next state is CHIPRST.
  - start while busy=1 is ignored; frame changes while busy are ignored.
- CHIPRST:
  - rstn_sc=0 for exactly RSTN_CYCLES cycles, then returns to 1.
  - ck_sc=0 and d_sc=0 throughout.
- SHIFT:
  - FRAME_W bit periods. Each period is a low phase (ck_sc=0, CLK_DIV cycles) followed by a high phase (ck_sc=1, CLK_DIV cycles).
  - d_sc is updated in the first cycle of the low phase and is stable across the rising ck_sc edge.
  - Bit order follows LSB_FIRST.
- VERIFY (only when VERIFY=1):
  - Same frame, same timing, sent a second time.
  - q_sc is sampled in the last cycle of each low phase, before ck_sc rises.
  - Sample k is compared to the bit sent in period k of the pass.
  - Any mismatch sets a sticky mismatch flag.
- FINISH: one cycle. done=1, busy=0, error=sticky flag, d_sc=0, ck_sc=0. The next state is IDLE.
- Timing: an accepted start at edge 0 gives busy=1 at cycle 1 and done at cycle 1+RSTN_CYCLES+2*CLK_DIV*FRAME_W*(1+VERIFY).
  - busy falls in the same cycle done rises.
  - start may be re-accepted in the cycle after done.
- Counters:
  - Bit counter width is clog2(FRAME_W); it wraps at FRAME_W-1 with no off-by-one.
  - The phase counter wraps at CLK_DIV-1.

Test Plan (FRAME_W=8, CLK_DIV=2, RSTN_CYCLES=3, LSB_FIRST=1, VERIFY=1, unless stated; q_sc driven by an 8-bit loopback register clocked on ck_sc rising with input d_sc):
- Reset check: hold rst 3 cycles → busy=0, done=0, error=0, d_sc=0, ck_sc=0, rstn_sc=1.
- Basic run: start with frame=8'hA5 → rstn_sc low cycles 1–3; first-pass d_sc sequence 1,0,1,0,0,1,0,1; 16 ck_sc rising edges in total; done pulse at cycle 68; error=0.
- Injected fault: same run but force q_sc inverted during VERIFY → done at cycle 68, error=1. error stays 1 until the next start, then clears in the cycle after that start.
- Mode variant: LSB_FIRST=0, VERIFY=0, frame=8'h01 → d_sc sequence 0,0,0,0,0,0,0,1; done at cycle 36; error=0.
- Handshake and abort:
  - start pulses at cycles 10 and 20 are ignored (a single done, at cycle 68).
  - rst asserted at cycle 30 → all outputs return to reset values at cycle 31, with no done pulse.
- Full-size run: FRAME_W=829, CLK_DIV=1, random frame → captured d_sc stream equals frame, LSB first; done at cycle 1+8+2*829*2; error=0.
